// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-stage register fields and control bits
// going in, stall/flush/forward selects coming back out.
interface hazard_ctrl_if;
  // Decode stage
  logic [4:0] RsD;
  logic [4:0] RtD;
  logic       BranchD;
  logic       Jump_RD;
  logic [3:0] MulOpD;
  logic [1:0] MTHILOD;
  logic [1:0] MFHILOD;
  // Execute stage
  logic [4:0] RsE;
  logic [4:0] RtE;
  logic [4:0] WriteRegE;
  logic       RegWriteE;
  logic       MemtoRegE;
  logic       cpztoRegE;
  logic [3:0] MulOpE;
  // Memory stage
  logic [4:0] WriteRegM;
  logic       RegWriteM;
  logic       MemtoRegM;
  logic       cpztoRegM;
  // Writeback stage
  logic [4:0] WriteRegW;
  logic       RegWriteW;
  // Exception / eret redirect
  logic       ExcFlush;
  // Controller outputs
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;
  logic       FlushM;
  logic       ForwardAD;
  logic       ForwardBD;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       MDBusy;

  // Pipeline datapath side: supplies stage state, consumes controls
  modport master (
    output RsD, RtD, BranchD, Jump_RD, MulOpD, MTHILOD, MFHILOD,
    output RsE, RtE, WriteRegE, RegWriteE, MemtoRegE, cpztoRegE, MulOpE,
    output WriteRegM, RegWriteM, MemtoRegM, cpztoRegM,
    output WriteRegW, RegWriteW, ExcFlush,
    input  StallF, StallD, FlushD, FlushE, FlushM,
    input  ForwardAD, ForwardBD, ForwardAE, ForwardBE, MDBusy
  );

  // Hazard controller side
  modport slave (
    input  RsD, RtD, BranchD, Jump_RD, MulOpD, MTHILOD, MFHILOD,
    input  RsE, RtE, WriteRegE, RegWriteE, MemtoRegE, cpztoRegE, MulOpE,
    input  WriteRegM, RegWriteM, MemtoRegM, cpztoRegM,
    input  WriteRegW, RegWriteW, ExcFlush,
    output StallF, StallD, FlushD, FlushE, FlushM,
    output ForwardAD, ForwardBD, ForwardAE, ForwardBE, MDBusy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use, branch-operand and
// HI/LO interlocks, exception flushes, operand forwarding selects, and the
// multiply/divide busy counter.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0] count_q;
  logic [3:0] count_d;

  logic start_e;
  logic start_is_div;
  logic md_busy;
  logic md_use_d;
  logic md_stall;
  logic load_stall;
  logic branch_stall;
  logic stall;

  // Destination-field hits; register 0 never counts as a producer.
  logic e_hits_rs_d, e_hits_rt_d;
  logic m_hits_rs_d, m_hits_rt_d;
  logic m_hits_rs_e, m_hits_rt_e;
  logic w_hits_rs_e, w_hits_rt_e;

  assign e_hits_rs_d = (hz.WriteRegE != 5'd0) && (hz.WriteRegE == hz.RsD);
  assign e_hits_rt_d = (hz.WriteRegE != 5'd0) && (hz.WriteRegE == hz.RtD);
  assign m_hits_rs_d = (hz.WriteRegM != 5'd0) && (hz.WriteRegM == hz.RsD);
  assign m_hits_rt_d = (hz.WriteRegM != 5'd0) && (hz.WriteRegM == hz.RtD);
  assign m_hits_rs_e = (hz.WriteRegM != 5'd0) && (hz.WriteRegM == hz.RsE);
  assign m_hits_rt_e = (hz.WriteRegM != 5'd0) && (hz.WriteRegM == hz.RtE);
  assign w_hits_rs_e = (hz.WriteRegW != 5'd0) && (hz.WriteRegW == hz.RsE);
  assign w_hits_rt_e = (hz.WriteRegW != 5'd0) && (hz.WriteRegW == hz.RtE);

  // Opcodes 1-2 start a multiply, 3-4 a divide; other nonzero codes only use HI/LO.
  assign start_e      = (hz.MulOpE >= 4'd1) && (hz.MulOpE <= 4'd4);
  assign start_is_div = (hz.MulOpE >= 4'd3);
  assign md_busy      = (count_q != 4'd0);

  // Busy counter next state: exceptions may not launch a new operation.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    count_d = count_q;
    if (hz.ExcFlush) begin
      if (md_busy) count_d = count_q - 4'd1;
    end else if (start_e && !md_busy) begin
      count_d = start_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_busy) begin
      count_d = count_q - 4'd1;
    end
  end

  // Busy counter register; reset aborts any in-flight window immediately.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (!reset) count_q <= 4'd0;
    else        count_q <= count_d;
  end

  // Stall and flush decisions from the current stage contents.
  always_comb begin
    md_use_d   = (hz.MulOpD != 4'd0) || (hz.MTHILOD != 2'd0) || (hz.MFHILOD != 2'd0);
    md_stall   = md_use_d && (md_busy || start_e);
    load_stall = (hz.MemtoRegE || hz.cpztoRegE) && (e_hits_rs_d || e_hits_rt_d);

    // jr/jalr only read rs; branches compare rs and rt in decode.
    branch_stall = (hz.BranchD || hz.Jump_RD) &&
                   ((hz.RegWriteE && (e_hits_rs_d || (hz.BranchD && e_hits_rt_d))) ||
                    ((hz.MemtoRegM || hz.cpztoRegM) &&
                     (m_hits_rs_d || (hz.BranchD && m_hits_rt_d))));

    stall     = md_stall || load_stall || branch_stall;
    hz.StallF = stall && !hz.ExcFlush;
    hz.StallD = stall && !hz.ExcFlush;
    hz.FlushE = stall || hz.ExcFlush;
    hz.FlushD = hz.ExcFlush;
    hz.FlushM = hz.ExcFlush;
  end

  // Forwarding selects: M has priority over W in execute; decode only takes ALU results from M.
  always_comb begin
    hz.ForwardAE = 2'd0;
    hz.ForwardBE = 2'd0;
    if (hz.RegWriteM && m_hits_rs_e)      hz.ForwardAE = 2'd2;
    else if (hz.RegWriteW && w_hits_rs_e) hz.ForwardAE = 2'd1;
    if (hz.RegWriteM && m_hits_rt_e)      hz.ForwardBE = 2'd2;
    else if (hz.RegWriteW && w_hits_rt_e) hz.ForwardBE = 2'd1;
    hz.ForwardAD = hz.RegWriteM && !hz.MemtoRegM && !hz.cpztoRegM && m_hits_rs_d;
    hz.ForwardBD = hz.RegWriteM && !hz.MemtoRegM && !hz.cpztoRegM && m_hits_rt_d;
  end

  assign hz.MDBusy = md_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, mul/div interlock, branch
// hazards, forwarding priority, exception flush and asynchronous reset.
module tb_hazard_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge, then settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.RsD = 0; hz.RtD = 0; hz.BranchD = 0; hz.Jump_RD = 0;
    hz.MulOpD = 0; hz.MTHILOD = 0; hz.MFHILOD = 0;
    hz.RsE = 0; hz.RtE = 0; hz.WriteRegE = 0; hz.RegWriteE = 0;
    hz.MemtoRegE = 0; hz.cpztoRegE = 0; hz.MulOpE = 0;
    hz.WriteRegM = 0; hz.RegWriteM = 0; hz.MemtoRegM = 0; hz.cpztoRegM = 0;
    hz.WriteRegW = 0; hz.RegWriteW = 0; hz.ExcFlush = 0;
  endtask

  function automatic logic [4:0] ctl();
    return {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.FlushM};
  endfunction

  // Count cycles with MDBusy high, sampling before each edge; bounded.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (hz.MDBusy) n++;
      tick();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #3;
    total++;
    if (hz.MDBusy !== 1'b0) begin
      bad++; $display("FAIL reset_mdbusy got=%b exp=0", hz.MDBusy);
    end
    total++;
    if (ctl() !== 5'b00000) begin
      bad++; $display("FAIL reset_ctl got=%b exp=00000", ctl());
    end
    tick();
    reset = 1'b1;
    tick();
    total++;
    if (hz.MDBusy !== 1'b0) begin
      bad++; $display("FAIL reset_idle_mdbusy got=%b exp=0", hz.MDBusy);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.WriteRegE = 8;
    hz.RsD = 8; hz.RtD = 1;
    #1;
    total++;
    if (ctl() !== 5'b11010) begin
      bad++; $display("FAIL loaduse_stall got=%b exp=11010", ctl());
    end
    clear_inputs();
    hz.MemtoRegM = 1; hz.RegWriteM = 1; hz.WriteRegM = 8;
    hz.RsE = 8; hz.RtE = 1;
    #1;
    total++;
    if ({ctl(), hz.ForwardAE, hz.ForwardBE} !== {5'b00000, 2'd2, 2'd0}) begin
      bad++; $display("FAIL loaduse_fwd_m got=%b/%0d/%0d exp=00000/2/0", ctl(), hz.ForwardAE, hz.ForwardBE);
    end
    clear_inputs();
    hz.RegWriteW = 1; hz.WriteRegW = 8; hz.RsE = 8; hz.RtE = 1;
    #1;
    total++;
    if ({hz.ForwardAE, hz.ForwardBE} !== {2'd1, 2'd0}) begin
      bad++; $display("FAIL loaduse_fwd_w got=%0d/%0d exp=1/0", hz.ForwardAE, hz.ForwardBE);
    end
  endtask

  task automatic test_mult();
    int n;
    clear_inputs();
    hz.MulOpE = 1; hz.MFHILOD = 1;
    #1;
    total++;
    if ({ctl(), hz.MDBusy} !== 6'b110100) begin
      bad++; $display("FAIL mult_start_stall got=%b exp=110100", {ctl(), hz.MDBusy});
    end
    tick();
    hz.MulOpE = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (hz.MDBusy === 1'b1 && hz.StallD === 1'b1) n++;
      tick();
    end
    total++;
    if (n != 5) begin
      bad++; $display("FAIL mult_busy_window got=%0d exp=5", n);
    end
    total++;
    if ({hz.MDBusy, hz.StallD, hz.FlushE} !== 3'b000) begin
      bad++; $display("FAIL mult_release got=%b exp=000", {hz.MDBusy, hz.StallD, hz.FlushE});
    end
  endtask

  task automatic test_div();
    int n;
    int stalls;
    clear_inputs();
    hz.MulOpE = 3; hz.RsD = 2; hz.RtD = 3;
    #1;
    stalls = hz.StallD ? 1 : 0;
    tick();
    hz.MulOpE = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (hz.MDBusy) n++;
      if (hz.StallD) stalls++;
      tick();
    end
    total++;
    if (n != 10) begin
      bad++; $display("FAIL div_busy_window got=%0d exp=10", n);
    end
    total++;
    if (stalls != 0) begin
      bad++; $display("FAIL div_indep_stall got=%0d exp=0", stalls);
    end
  endtask

  // A second start while busy must not reload the counter.
  task automatic test_forced_start();
    int n;
    clear_inputs();
    hz.MulOpE = 1;
    tick();
    hz.MulOpE = 3;
    n = hz.MDBusy ? 1 : 0;
    tick();
    hz.MulOpE = 0;
    for (int i = 0; i < 20; i++) begin
      if (hz.MDBusy) n++;
      tick();
    end
    total++;
    if (n != 5) begin
      bad++; $display("FAIL forced_start_ignored got=%0d exp=5", n);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    hz.BranchD = 1; hz.RsD = 3; hz.RtD = 4;
    hz.RegWriteE = 1; hz.WriteRegE = 4;
    #1;
    total++;
    if (ctl() !== 5'b11010) begin
      bad++; $display("FAIL branch_e_stall got=%b exp=11010", ctl());
    end
    hz.RegWriteE = 0; hz.WriteRegE = 0;
    hz.RegWriteM = 1; hz.WriteRegM = 3;
    #1;
    total++;
    if ({ctl(), hz.ForwardAD, hz.ForwardBD} !== 7'b0000010) begin
      bad++; $display("FAIL branch_fwd_ad got=%b exp=0000010", {ctl(), hz.ForwardAD, hz.ForwardBD});
    end
    hz.MemtoRegM = 1;
    #1;
    total++;
    if ({ctl(), hz.ForwardAD} !== 6'b110100) begin
      bad++; $display("FAIL branch_m_load got=%b exp=110100", {ctl(), hz.ForwardAD});
    end
    clear_inputs();
    hz.Jump_RD = 1; hz.RsD = 3; hz.RtD = 4;
    hz.RegWriteE = 1; hz.WriteRegE = 4;
    #1;
    total++;
    if (ctl() !== 5'b00000) begin
      bad++; $display("FAIL jr_rt_ignored got=%b exp=00000", ctl());
    end
  endtask

  task automatic test_forward_prio();
    clear_inputs();
    hz.RegWriteM = 1; hz.WriteRegM = 5;
    hz.RegWriteW = 1; hz.WriteRegW = 5;
    hz.RsE = 5; hz.RtE = 5;
    #1;
    total++;
    if ({hz.ForwardAE, hz.ForwardBE} !== {2'd2, 2'd2}) begin
      bad++; $display("FAIL fwd_m_priority got=%0d/%0d exp=2/2", hz.ForwardAE, hz.ForwardBE);
    end
    hz.WriteRegM = 6;
    #1;
    total++;
    if ({hz.ForwardAE, hz.ForwardBE} !== {2'd1, 2'd1}) begin
      bad++; $display("FAIL fwd_w_only got=%0d/%0d exp=1/1", hz.ForwardAE, hz.ForwardBE);
    end
    hz.WriteRegM = 0; hz.WriteRegW = 0; hz.RsE = 0; hz.RtE = 0;
    #1;
    total++;
    if ({hz.ForwardAE, hz.ForwardBE} !== {2'd0, 2'd0}) begin
      bad++; $display("FAIL fwd_reg0 got=%0d/%0d exp=0/0", hz.ForwardAE, hz.ForwardBE);
    end
  endtask

  task automatic test_exc_flush();
    int n;
    clear_inputs();
    hz.MulOpE = 3;
    tick();
    hz.MulOpE = 0;
    tick(); tick(); tick();
    hz.MemtoRegE = 1; hz.WriteRegE = 8; hz.RsD = 8;
    hz.ExcFlush = 1;
    #1;
    total++;
    if ({ctl(), hz.MDBusy} !== 6'b001111) begin
      bad++; $display("FAIL exc_flush_ctl got=%b exp=001111", {ctl(), hz.MDBusy});
    end
    tick();
    clear_inputs();
    count_busy(n);
    total++;
    if (n != 6) begin
      bad++; $display("FAIL exc_count_decrement got=%0d exp=6", n);
    end
    hz.ExcFlush = 1; hz.MulOpE = 1;
    tick();
    clear_inputs();
    #1;
    total++;
    if (hz.MDBusy !== 1'b0) begin
      bad++; $display("FAIL exc_blocks_load got=%b exp=0", hz.MDBusy);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    hz.MulOpE = 2;
    tick();
    hz.MulOpE = 0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (hz.MDBusy !== 1'b0) begin
      bad++; $display("FAIL reset_async got=%b exp=0", hz.MDBusy);
    end
    @(negedge clk);
    reset = 1'b1;
    hz.MulOpE = 1;
    tick();
    hz.MulOpE = 0;
    total++;
    if (hz.MDBusy !== 1'b1) begin
      bad++; $display("FAIL reset_first_edge got=%b exp=1", hz.MDBusy);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_use();
    test_mult();
    test_div();
    test_forced_start();
    test_branch();
    test_forward_prio();
    test_exc_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the five-stage pipeline.
- Produces the stall, flush and forwarding selects for the IF/ID, ID/EX and EX/MEM pipeline registers. FlushE drives the ID/EX `clr` input; StallD drives the IF/ID enable.
- Owns the multiply/divide busy counter and interlocks dependent HI/LO instructions behind it.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu starts in E (1..15)
DIV_CYCLES, 10, busy cycles after a div/divu starts in E (1..15)

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
RsD  in  5  rs field of instruction in D
RtD  in  5  rt field of instruction in D
BranchD  in  1  D holds a branch comparing in D
Jump_RD  in  1  D holds jr/jalr
MulOpD  in  4  mul/div opcode in D (0 = none)
MTHILOD  in  2  mthi/mtlo in D (0 = none)
MFHILOD  in  2  mfhi/mflo in D (0 = none)
RsE  in  5  rs in E
RtE  in  5  rt in E
WriteRegE  in  5  destination register in E
RegWriteE  in  1  E writes the GPR file
MemtoRegE  in  1  E is a load
cpztoRegE  in  1  E is mfc0
MulOpE  in  4  mul/div opcode in E
WriteRegM  in  5  destination in M
RegWriteM  in  1  M writes the GPR file
MemtoRegM  in  1  M is a load
cpztoRegM  in  1  M is mfc0
WriteRegW  in  5  destination in W
RegWriteW  in  1  W writes the GPR file
ExcFlush  in  1  exception or eret taken this cycle
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX
FlushM  out  1  clear EX/MEM
ForwardAD  out  1  D rs operand from M result
ForwardBD  out  1  D rt operand from M result
ForwardAE  out  2  E rs source: 0 = reg, 1 = W, 2 = M
ForwardBE  out  2  E rt source: 0 = reg, 1 = W, 2 = M
MDBusy  out  1  mul/div unit busy (registered)

Behaviour:
- Register 0 is never a hazard or forward source; every match below also requires the stage's register field to be nonzero.
- All outputs except MDBusy are combinational from inputs and the counter.
- MulOp classes: 1–2 are mult class, 3–4 are div class; any other nonzero value is "md use" without a start.
- MDBusy = (count != 0).
- Counter (4 bits), on every posedge clk:
  - if ExcFlush: keep decrementing; no load;
  - else if StartE (MulOpE in 1..4) and count == 0: load MULT_CYCLES or DIV_CYCLES by class;
  - else if count != 0: count - 1.
- mdStall = (MulOpD != 0 | MTHILOD != 0 | MFHILOD != 0) & (MDBusy | StartE).
- loadStall = (MemtoRegE | cpztoRegE) & WriteRegE matches RsD or RtD.
- branchStall = (BranchD | Jump_RD) & [(RegWriteE & WriteRegE matches RsD, or RtD for branches only) | ((MemtoRegM | cpztoRegM) & WriteRegM matches the same operands)].
- stall = mdStall | loadStall | branchStall.
  - StallF = StallD = stall & !ExcFlush.
  - FlushE = stall | ExcFlush.
- FlushD = FlushM = ExcFlush. ExcFlush overrides all stalls.
- ForwardAE/BE priority: M (2) if RegWriteM & WriteRegM matches RsE/RtE; else W (1) if RegWriteW matches; else 0.
- ForwardAD/BD = RegWriteM & !MemtoRegM & !cpztoRegM & WriteRegM matches RsD/RtD.
- Reset (reset = 0, asynchronous): count = 0, MDBusy = 0 immediately. Combinational outputs continue to follow their inputs.
- Reset mid-operation aborts the busy window. After reset deasserts, the first edge is normal.
- A start while MDBusy = 1 cannot occur: mdStall prevents it. If it is forced anyway, it is ignored (no reload).

Test Plan:
- lw $8 in E, D = add $9,$8,$1 → StallF = StallD = FlushE = 1; next cycle with the lw in M → all 0 and ForwardAE = 2 (once the lw is in W: ForwardAE = 1).
- mult in E (MulOpE = 1), MFHILOD = 1 → stall in start cycle; MDBusy = 1 for 5 cycles; stall drops the cycle count reaches 0.
- div start → MDBusy high exactly 10 cycles; an independent add in D is never stalled.
- beq $3,$4 in D, E writes $4 → stall 1 cycle; M ALU writes $3 → ForwardAD = 1, no stall.
- M and W both write $5, E reads $5 in rs and rt → ForwardAE = ForwardBE = 2. A write to $0 in M → ForwardAE = 0.
- ExcFlush during loadStall with count = 7 → FlushD = FlushE = FlushM = 1, StallF = 0, count next = 6; assert reset = 0 mid-count → MDBusy = 0 without a clock edge.
